rv_sdram_arbiter: RTL and testbench
===================================

Name: rv_sdram_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter. It shares the SDRAM bridge port (HPS DDR3, 32-bit) between the RISC-V core's instruction-fetch port (m0) and data port (m1). Single-beat transfers with pipelined reads: a tag FIFO records which master issued each accepted read and routes readdatavalid/readdata back to it. Round-robin grant; no bursts.

Parameters:
ADDR_W, 32, address width of masters and slave (byte address, passed through unchanged)
DATA_W, 32, data width; byteenable width is DATA_W/8
MAX_PENDING, 8, max outstanding reads; power of 2, >=2; tag FIFO depth

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
m0_address  in  ADDR_W  fetch master address
m0_read  in  1  fetch read request (m0 has no write port)
m0_waitrequest  out  1  stall to fetch master
m0_readdata  out  DATA_W  read data to fetch master
m0_readdatavalid  out  1  read data valid to fetch master
m1_address  in  ADDR_W  data master address
m1_read  in  1  data read request
m1_write  in  1  data write request
m1_writedata  in  DATA_W  write data
m1_byteenable  in  DATA_W/8  byte enables
m1_waitrequest  out  1  stall to data master
m1_readdata  out  DATA_W  read data to data master
m1_readdatavalid  out  1  read data valid to data master
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  DATA_W/8  slave byte enables (all ones for m0 reads)
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read data valid
pending_count  out  log2(MAX_PENDING)+1  outstanding reads
err_unexpected_rdv  out  1  sticky: readdatavalid with empty tag FIFO

Behaviour:
- Clocking: all state on rising clk_clk; reset_reset synchronous, active-high.
- Reset values: state IDLE, grant none, last_grant=m1 (so m0 wins first tie), FIFO empty, pending_count=0, err_unexpected_rdv=0, s_read=s_write=0, m0/m1_waitrequest=1, m*_readdatavalid=0, readdata=0.
- FSM IDLE: eligible requester = m0 if m0_read; m1 if m1_write, or m1_read with FIFO not full. Reads from either master are ineligible while pending_count==MAX_PENDING. One eligible -> grant it. Both eligible -> grant the one not equal to last_grant. Register grant, go BUSY. No slave command is driven in IDLE.
- FSM BUSY: s_address/s_read/s_write/s_writedata/s_byteenable muxed combinationally from the granted master; the other master's command is masked. Granted master's waitrequest = s_waitrequest; ungranted waitrequest = 1. Accept = granted command asserted && !s_waitrequest. On accept: if read, push grant ID into FIFO; last_grant <= grant; go IDLE. If the granted master drops its request while stalled (Avalon protocol violation), return to IDLE with no push.
- m1_read && m1_write together: write wins, read ignored.
- Timing: minimum 2 cycles per transfer (IDLE arbitration + BUSY accept); max 1 transfer per 2 cycles.
- Read return: on s_readdatavalid, pop FIFO head. Pulse that master's readdatavalid combinationally in the same cycle, with readdata = s_readdata. Zero-cycle latency through the arbiter. Returns are in order.
- Push and pop in the same cycle: pending_count unchanged; FIFO pointers wrap modulo MAX_PENDING.
- s_readdatavalid with FIFO empty: data dropped, no master valid, err_unexpected_rdv set until reset.
- Writes are not tracked (no write response).
- Reset mid-operation: current grant abandoned, FIFO flushed. Late slave responses after reset set err_unexpected_rdv.

Test Plan:
- Single m0 read at 0x100, s_waitrequest=0, slave returns 0xDEADBEEF 3 cycles later -> s_read high exactly 1 cycle; m0_readdatavalid 1 cycle with 0xDEADBEEF; m1_readdatavalid stays 0; pending_count 0->1->0.
- m0 read and m1 write (0x200, data 0x12345678, be 0xF) asserted together from reset -> m0 granted first, m1 next; s_write carries 0x12345678/0xF; grants alternate m0,m1,m0,m1 while both persist.
- Interleaved reads m0@0x10, m1@0x20, m0@0x30; slave returns A,B,C in order -> m0 gets A then C, m1 gets B; pending_count peaks at 3.
- 8 m1 reads, no returns -> 9th read held (m1_waitrequest=1, s_read=0); one return in the same cycle a slot frees -> 9th issues; pending_count returns to 8 afterward.
- s_waitrequest held high 5 cycles during a granted m1 write -> s_write stable 5 cycles with m1_waitrequest=1, m0 blocked; released -> accept in cycle 6.
- s_readdatavalid with no outstanding reads -> err_unexpected_rdv=1 and stays set; reset_reset pulse -> cleared, pending_count=0, waitrequests=1.

Source files
------------

// File: rtl/rv_sdram_arbiter_if.sv
// rv_sdram_arbiter_if
// One single-beat Avalon-MM port with pipelined reads. The arbiter has two
// masters and one slave, and each of them uses one instance of this bundle.
//   master modport : the side that issues commands (address/read/write/writedata/byteenable)
//   slave  modport : the side that answers (waitrequest/readdata/readdatavalid)
interface rv_sdram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/rv_sdram_arbiter.sv
// rv_sdram_arbiter
// Shares one SDRAM bridge port between the RISC-V fetch port (m0, read only)
// and the data port (m1). Arbitration is round-robin, one single-beat command
// every two cycles at most. A tag FIFO records which master owns each
// outstanding read, and the FIFO routes every read return back to that master
// in the same cycle.
// Ports:
//   clk_clk, reset_reset   : clock, synchronous active-high reset
//   m0 (slave modport)     : fetch master; its write/writedata/byteenable are ignored
//   m1 (slave modport)     : data master
//   s  (master modport)    : SDRAM bridge slave
//   pending_count          : number of outstanding reads
//   err_unexpected_rdv     : sticky, set when the slave returns data that nobody requested
module rv_sdram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,
  rv_sdram_arbiter_if.slave              m0,
  rv_sdram_arbiter_if.slave              m1,
  rv_sdram_arbiter_if.master             s,
  output logic [$clog2(MAX_PENDING):0]   pending_count,
  output logic                           err_unexpected_rdv
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_W / 8;

  localparam logic G_M0 = 1'b0;
  localparam logic G_M1 = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic               grant_r, grant_nxt_s;
  logic               last_grant_r, last_grant_nxt_s;
  logic               tag_mem_r [MAX_PENDING];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               err_r;

  logic               fifo_full_s, fifo_empty_s;
  logic               m0_elig_s, m1_elig_s;
  logic               cmd_rd_s, cmd_wr_s;
  logic               push_s, pop_s;
  logic               head_tag_s;

  assign fifo_full_s  = (count_r == CNT_W'(MAX_PENDING));
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  // When m1 raises write and read together, the write wins. So an m1 write is
  // always eligible, whatever the FIFO level.
  assign m0_elig_s    = m0.read & ~fifo_full_s;
  assign m1_elig_s    = m1.write | (m1.read & ~fifo_full_s);
  assign head_tag_s   = tag_mem_r[rd_ptr_r];

  assign pending_count      = count_r;
  assign err_unexpected_rdv = err_r;

  // Arbitration FSM next-state logic and the slave command mux for the granted master.
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    push_s           = 1'b0;
    cmd_rd_s         = 1'b0;
    cmd_wr_s         = 1'b0;
    s.address        = {ADDR_W{1'b0}};
    s.read           = 1'b0;
    s.write          = 1'b0;
    s.writedata      = {DATA_W{1'b0}};
    s.byteenable     = {BE_W{1'b0}};
    m0.waitrequest   = 1'b1;
    m1.waitrequest   = 1'b1;
    if (reset_reset) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (m0_elig_s && m1_elig_s) begin
            grant_nxt_s = ~last_grant_r;
            state_nxt_s = ST_BUSY;
          end else if (m1_elig_s) begin
            grant_nxt_s = G_M1;
            state_nxt_s = ST_BUSY;
          end else if (m0_elig_s) begin
            grant_nxt_s = G_M0;
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (grant_r == G_M1) begin
            cmd_wr_s       = m1.write;
            cmd_rd_s       = m1.read & ~m1.write;
            s.address      = m1.address;
            s.writedata    = m1.writedata;
            s.byteenable   = m1.byteenable;
            m1.waitrequest = s.waitrequest;
          end else begin
            cmd_rd_s       = m0.read;
            s.address      = m0.address;
            s.byteenable   = {BE_W{1'b1}};
            m0.waitrequest = s.waitrequest;
          end
          s.read  = cmd_rd_s;
          s.write = cmd_wr_s;
          if (!(cmd_rd_s || cmd_wr_s)) begin
            // The master withdrew a stalled request, so give up the grant and record nothing.
            state_nxt_s = ST_IDLE;
          end else if (!s.waitrequest) begin
            push_s           = cmd_rd_s;
            last_grant_nxt_s = grant_r;
            state_nxt_s      = ST_IDLE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Read-return routing. The FIFO head selects which master sees the data, with no added latency.
  always_comb begin
    pop_s               = s.readdatavalid & ~fifo_empty_s & ~reset_reset;
    m0.readdatavalid    = pop_s & (head_tag_s == G_M0);
    m1.readdatavalid    = pop_s & (head_tag_s == G_M1);
    if (m0.readdatavalid) begin
      m0.readdata = s.readdata;
    end else begin
      m0.readdata = {DATA_W{1'b0}};
    end
    if (m1.readdatavalid) begin
      m1.readdata = s.readdata;
    end else begin
      m1.readdata = {DATA_W{1'b0}};
    end
  end

  // FSM state, grant and round-robin history registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= G_M0;
      last_grant_r <= G_M1;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Tag FIFO storage. Entries are meaningful only between push and pop, so they need no reset.
  always_ff @(posedge clk_clk) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r] <= grant_r;
    end
  end

  // Tag FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for read data that arrives with no read outstanding.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      err_r <= 1'b0;
    end else if (s.readdatavalid && fifo_empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_rv_sdram_arbiter.sv
// Directed bench for rv_sdram_arbiter. A transaction-level model holds the
// current owner, the round-robin history and a queue of read owners. On each
// falling edge, a compare process predicts every output from that model.
// Short literal checks after each scenario pin the model itself.
module tb_rv_sdram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  rv_sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  rv_sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();
  logic [3:0] pending_count;
  logic       err;

  rv_sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
    .clk_clk            (clk),
    .reset_reset        (rst),
    .m0                 (m0_if),
    .m1                 (m1_if),
    .s                  (s_if),
    .pending_count      (pending_count),
    .err_unexpected_rdv (err)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int          mdl_owner = -1;
  int          mdl_last  = 1;
  int          mdl_q[$];
  bit          mdl_err   = 1'b0;
  int          grant_log[$];
  logic [31:0] wdata_log[$];
  logic [31:0] m0_got[$];
  logic [31:0] m1_got[$];
  int          sread_cycles = 0;
  int          peak = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit          e_w0, e_w1, e_rd, e_wr, e_v0, e_v1, pop, cmd, el0, el1;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    int          sz;
    e_w0 = 1'b1; e_w1 = 1'b1; e_rd = 1'b0; e_wr = 1'b0;
    e_v0 = 1'b0; e_v1 = 1'b0; pop = 1'b0;
    e_addr = 32'h0; e_wd = 32'h0; e_be = 4'h0;
    sz = mdl_q.size();
    chk("pending_count", 64'(pending_count), 64'(sz));
    chk("err_unexpected_rdv", 64'(err), 64'(mdl_err));
    if (pending_count > 4'(peak)) peak = int'(pending_count);
    if (s_if.read) sread_cycles++;
    if (rst) begin
      chk("rst_m0_wait", 64'(m0_if.waitrequest), 64'd1);
      chk("rst_m1_wait", 64'(m1_if.waitrequest), 64'd1);
      chk("rst_s_cmd", 64'({s_if.read, s_if.write}), 64'd0);
      chk("rst_rdv", 64'({m0_if.readdatavalid, m1_if.readdatavalid}), 64'd0);
      chk("rst_rdata", 64'({m0_if.readdata, m1_if.readdata}), 64'd0);
      mdl_owner = -1; mdl_last = 1; mdl_q.delete(); mdl_err = 1'b0;
      return;
    end
    if (mdl_owner == 0) begin
      e_rd = m0_if.read; e_addr = m0_if.address; e_be = 4'hF;
      e_w0 = s_if.waitrequest;
    end else if (mdl_owner == 1) begin
      e_wr = m1_if.write; e_rd = m1_if.read && !m1_if.write;
      e_addr = m1_if.address; e_be = m1_if.byteenable; e_wd = m1_if.writedata;
      e_w1 = s_if.waitrequest;
    end
    cmd = e_rd || e_wr;
    chk("s_read", 64'(s_if.read), 64'(e_rd));
    chk("s_write", 64'(s_if.write), 64'(e_wr));
    chk("m0_waitrequest", 64'(m0_if.waitrequest), 64'(e_w0));
    chk("m1_waitrequest", 64'(m1_if.waitrequest), 64'(e_w1));
    if (cmd) begin
      chk("s_address", 64'(s_if.address), 64'(e_addr));
      chk("s_byteenable", 64'(s_if.byteenable), 64'(e_be));
    end
    if (e_wr) chk("s_writedata", 64'(s_if.writedata), 64'(e_wd));
    if (s_if.readdatavalid) begin
      if (sz > 0) begin
        pop = 1'b1;
        if (mdl_q[0] == 0) e_v0 = 1'b1; else e_v1 = 1'b1;
      end else begin
        mdl_err = 1'b1;
      end
    end
    chk("m0_readdatavalid", 64'(m0_if.readdatavalid), 64'(e_v0));
    chk("m1_readdatavalid", 64'(m1_if.readdatavalid), 64'(e_v1));
    if (e_v0) begin
      chk("m0_readdata", 64'(m0_if.readdata), 64'(s_if.readdata));
      m0_got.push_back(m0_if.readdata);
    end
    if (e_v1) begin
      chk("m1_readdata", 64'(m1_if.readdata), 64'(s_if.readdata));
      m1_got.push_back(m1_if.readdata);
    end
    // what the coming rising edge must do
    if (mdl_owner == -1) begin
      el0 = m0_if.read && (sz < MP);
      el1 = m1_if.write || (m1_if.read && (sz < MP));
      if (el0 && el1) mdl_owner = (mdl_last == 0) ? 1 : 0;
      else if (el0) mdl_owner = 0;
      else if (el1) mdl_owner = 1;
    end else if (!cmd) begin
      mdl_owner = -1;
    end else if (!s_if.waitrequest) begin
      if (e_rd) mdl_q.push_back(mdl_owner);
      if (e_wr) wdata_log.push_back(e_wd);
      grant_log.push_back(mdl_owner);
      mdl_last  = mdl_owner;
      mdl_owner = -1;
    end
    if (pop) void'(mdl_q.pop_front());
  endtask

  // compare process
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int m);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (((m == 0) ? m0_if.waitrequest : m1_if.waitrequest) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout_m%0d actual=stalled required=accepted", m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic m0_rd(input logic [31:0] a);
    m0_if.address = a;
    m0_if.read    = 1'b1;
    wait_acc(0);
    m0_if.read    = 1'b0;
  endtask

  task automatic m1_op(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m1_if.address    = a;
    m1_if.writedata  = d;
    m1_if.byteenable = be;
    m1_if.write      = wr;
    m1_if.read       = !wr;
    wait_acc(1);
    m1_if.write = 1'b0;
    m1_if.read  = 1'b0;
  endtask

  task automatic slave_ret(input logic [31:0] d);
    s_if.readdatavalid = 1'b1;
    s_if.readdata      = d;
    @(posedge clk);
    #1;
    s_if.readdatavalid = 1'b0;
    s_if.readdata      = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int stable_n;
    m0_if.address = 32'h0; m0_if.read = 1'b0; m0_if.write = 1'b0;
    m0_if.writedata = 32'h0; m0_if.byteenable = 4'h0;
    m1_if.address = 32'h0; m1_if.read = 1'b0; m1_if.write = 1'b0;
    m1_if.writedata = 32'h0; m1_if.byteenable = 4'h0;
    s_if.waitrequest = 1'b0; s_if.readdata = 32'h0; s_if.readdatavalid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("reset_pending", 64'(pending_count), 64'd0);
    chk("reset_waits", 64'({m0_if.waitrequest, m1_if.waitrequest}), 64'd3);

    // single m0 read, data returned 3 cycles later
    sread_cycles = 0; peak = 0;
    m0_rd(32'h100);
    idle(2);
    slave_ret(32'hDEADBEEF);
    idle(2);
    chk("t1_s_read_cycles", 64'(sread_cycles), 64'd1);
    chk("t1_m0_count", 64'(m0_got.size()), 64'd1);
    chk("t1_m0_data", 64'(m0_got[0]), 64'hDEADBEEF);
    chk("t1_m1_count", 64'(m1_got.size()), 64'd0);
    chk("t1_peak", 64'(peak), 64'd1);
    chk("t1_pending_end", 64'(pending_count), 64'd0);

    // m0 reads against m1 writes from reset: grants alternate
    do_reset();
    grant_log.delete(); wdata_log.delete();
    fork
      begin
        m0_rd(32'h40);
        m0_rd(32'h44);
      end
      begin
        m1_op(1'b1, 32'h200, 32'h12345678, 4'hF);
        m1_op(1'b1, 32'h200, 32'h12345678, 4'hF);
      end
    join
    chk("t2_grants", 64'(grant_log.size()), 64'd4);
    chk("t2_order", 64'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), 64'b0101);
    chk("t2_wdata", 64'(wdata_log[0]), 64'h12345678);
    idle(1);
    slave_ret(32'hA1);
    slave_ret(32'hA2);
    idle(1);

    // interleaved reads returned in order
    m0_got.delete(); m1_got.delete(); peak = 0;
    m0_rd(32'h10);
    m1_op(1'b0, 32'h20, 32'h0, 4'hF);
    m0_rd(32'h30);
    slave_ret(32'hAAAA0001);
    slave_ret(32'hBBBB0002);
    slave_ret(32'hCCCC0003);
    idle(1);
    chk("t3_m0_count", 64'(m0_got.size()), 64'd2);
    chk("t3_m0_first", 64'(m0_got[0]), 64'hAAAA0001);
    chk("t3_m0_second", 64'(m0_got[1]), 64'hCCCC0003);
    chk("t3_m1_data", 64'(m1_got[0]), 64'hBBBB0002);
    chk("t3_peak", 64'(peak), 64'd3);

    // fill the tag FIFO, then the ninth read waits for a free slot
    for (int i = 0; i < 8; i++) m1_op(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'hF);
    m1_if.address = 32'h2000; m1_if.byteenable = 4'hF; m1_if.read = 1'b1;
    idle(3);
    @(negedge clk);
    chk("t4_hold_wait", 64'(m1_if.waitrequest), 64'd1);
    chk("t4_hold_sread", 64'(s_if.read), 64'd0);
    chk("t4_full", 64'(pending_count), 64'd8);
    @(posedge clk);
    #1;
    slave_ret(32'h00000F00);
    wait_acc(1);
    m1_if.read = 1'b0;
    chk("t4_refill", 64'(pending_count), 64'd8);
    for (int i = 0; i < 8; i++) slave_ret(32'h00000F01 + 32'(i));
    idle(1);
    chk("t4_drained", 64'(pending_count), 64'd0);

    // slave stalls a granted m1 write for 5 cycles while m0 waits
    s_if.waitrequest = 1'b1;
    m1_if.address = 32'h300; m1_if.writedata = 32'hCAFEF00D; m1_if.byteenable = 4'h3;
    m1_if.write = 1'b1;
    idle(1);
    m0_if.address = 32'h50; m0_if.read = 1'b1;
    stable_n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_if.write && m1_if.waitrequest && m0_if.waitrequest && s_if.writedata == 32'hCAFEF00D)
        stable_n++;
      @(posedge clk);
      #1;
    end
    chk("t5_stall_cycles", 64'(stable_n), 64'd5);
    s_if.waitrequest = 1'b0;
    wait_acc(1);
    m1_if.write = 1'b0;
    wait_acc(0);
    m0_if.read = 1'b0;
    slave_ret(32'h5A5A5A5A);
    idle(1);
    chk("t5_pending_end", 64'(pending_count), 64'd0);

    // unexpected read data is flagged and held until reset
    chk("t6_err_before", 64'(err), 64'd0);
    slave_ret(32'hBAD0BAD0);
    idle(3);
    chk("t6_err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    idle(1);
    chk("t6_err_cleared", 64'(err), 64'd0);
    chk("t6_pending", 64'(pending_count), 64'd0);
    rst = 1'b0;
    idle(2);
    chk("t6_waits", 64'({m0_if.waitrequest, m1_if.waitrequest}), 64'd3);
    chk("t6_err_after", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
